logic_op_pipe: RTL and testbench

- Parametrised successor to the team's single-bit assign / always_comb / always_ff comparison block.
- Computes a selectable bitwise logic operation on two WIDTH-bit operands.
- Exposes the result both combinationally and through a STAGES-deep registered pipeline with valid/ready flow control and per-stage bubble collapsing.
- Sits between an operand producer and a result consumer; also serves as the team's reference for comparing combinational and pipelined timing.

---
 rtl/logic_op_pipe.sv | 126 ++++++++++++
 tb/tb_logic_op_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_pipe
// Purpose  : Bitwise logic op on two WIDTH-bit operands, combinational and
//            through a STAGES-deep valid/ready pipeline with bubble collapsing.
//            Define LOGIC_OP_PIPE_PARITY_EN to add a pipelined out_parity.
// Revision : 1.0 - initial release
// ============================================================================
module logic_op_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] out_comb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef LOGIC_OP_PIPE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NAND  = 3'b011;
  localparam logic [2:0] OP_NOR   = 3'b100;
  localparam logic [2:0] OP_XNOR  = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;
  localparam logic [2:0] OP_NOTA  = 3'b111;

  logic [WIDTH-1:0]  result;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] empt;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  d [STAGES];
  logic              accept;

  always_comb begin
    result = '0;
    case (op)
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NAND:  result = ~(a & b);
      OP_NOR:   result = ~(a | b);
      OP_XNOR:  result = ~(a ^ b);
      OP_PASSA: result = a;
      OP_NOTA:  result = ~a;
      default:  result = '0;
    endcase
  end

  assign out_comb = result;

  // Emptying ripples from the output back so a stalled tail still lets
  // upstream bubbles collapse.
  always_comb begin
    empt = '0;
    empt[STAGES-1] = v[STAGES-1] & out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      empt[i] = v[i] & (~v[i+1] | empt[i+1]);
    end
  end

  assign load     = ~v | empt;
  assign in_ready = load[0];
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        v[0] <= accept;
        if (accept) begin
          d[0] <= result;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            d[i] <= d[i-1];
          end
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic [STAGES-1:0] p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else begin
      if (load[0] && accept) begin
        p[0] <= ^result;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i] && v[i-1]) begin
          p[i] <= p[i-1];
        end
      end
    end
  end

  assign out_parity = p[STAGES-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_op_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_op_pipe
// Purpose  : Scoreboard bench for logic_op_pipe (STAGES=2 and STAGES=3 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_op_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       in_valid = 1'b0;
  logic       sel = 1'b0;
  logic       or2 = 1'b1;
  logic       or3 = 1'b1;
  logic       iv2, iv3, ir2, ir3, ov2, ov3;
  logic [7:0] oc2, oc3, od2, od3;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic       op2p, op3p;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         acc;
    int         lat;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t e2, e3;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0] sweep_exp [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};

  assign iv2 = in_valid & ~sel;
  assign iv3 = in_valid & sel;

  logic_op_pipe #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .a(a), .b(b), .op(op), .out_comb(oc2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2)
`ifdef LOGIC_OP_PIPE_PARITY_EN
    , .out_parity(op2p)
`endif
  );

  logic_op_pipe #(.WIDTH(8), .STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3),
    .a(a), .b(b), .op(op), .out_comb(oc3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3)
`ifdef LOGIC_OP_PIPE_PARITY_EN
    , .out_parity(op3p)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitors: pop the oldest expected beat on every output handshake.
  always @(negedge clk) begin
    if (ov2 && or2) begin
      if (q2.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out2: got %0h expected no beat", od2);
      end else begin
        e2 = q2.pop_front();
        check("out_data2", {24'd0, od2}, {24'd0, e2.data});
`ifdef LOGIC_OP_PIPE_PARITY_EN
        check("out_parity2", {31'd0, op2p}, {31'd0, e2.par});
`endif
        if (e2.lat != 0) check("latency2", cyc - e2.acc, e2.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (ov3 && or3) begin
      if (q3.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out3: got %0h expected no beat", od3);
      end else begin
        e3 = q3.pop_front();
        check("out_data3", {24'd0, od3}, {24'd0, e3.data});
`ifdef LOGIC_OP_PIPE_PARITY_EN
        check("out_parity3", {31'd0, op3p}, {31'd0, e3.par});
`endif
        if (e3.lat != 0) check("latency3", cyc - e3.acc, e3.lat);
      end
    end
  end

  // One-cycle beat attempt; pushes the expected result only if accepted.
  task automatic try_beat(input logic s, input logic [7:0] ta, input logic [7:0] tbv,
                          input logic [2:0] top, input logic [7:0] texp, input logic tpar,
                          input logic exp_acc, input int lat);
    logic got;
    int   acc;
    exp_t ent;
    sel = s; a = ta; b = tbv; op = top; in_valid = 1'b1;
    @(negedge clk);
    check(s ? "out_comb3" : "out_comb2", {24'd0, (s ? oc3 : oc2)}, {24'd0, texp});
    got = s ? ir3 : ir2;
    check(s ? "in_ready3" : "in_ready2", {31'd0, got}, {31'd0, exp_acc});
    acc = cyc;
    @(posedge clk);
    if (got) begin
      ent.data = texp; ent.par = tpar; ent.acc = acc; ent.lat = lat;
      if (s) q3.push_back(ent);
      else   q2.push_back(ent);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (q2.size() == 0 && q3.size() == 0) break;
    end
    check(name, q2.size() + q3.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset / idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    a = 8'hF0; b = 8'h3C; op = 3'b010;
    #1;
    check("comb_in_reset", {24'd0, oc2}, 32'hCC);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid2", {31'd0, ov2}, 0);
    check("rst_out_data2", {24'd0, od2}, 0);
    check("rst_in_ready2", {31'd0, ir2}, 1);
    check("rst_out_valid3", {31'd0, ov3}, 0);
    check("rst_in_ready3", {31'd0, ir3}, 1);
    check("idle_out_comb", {24'd0, oc2}, 32'hCC);
    repeat (3) @(negedge clk);
    check("idle_no_capture", {31'd0, ov2}, 0);
    @(posedge clk);
    #1;

    // Op sweep, back-to-back, latency 2
    or2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      try_beat(1'b0, 8'hF0, 8'h3C, 3'(i), sweep_exp[i], 1'b0, 1'b1, 2);
    end
    drain("sweep_drain");

    // Backpressure on STAGES=2
    or2 = 1'b0;
    try_beat(1'b0, 8'h12, 8'h34, 3'b000, 8'h10, 1'b1, 1'b1, 0);
    try_beat(1'b0, 8'h12, 8'h34, 3'b001, 8'h36, 1'b0, 1'b1, 0);
    try_beat(1'b0, 8'h12, 8'h34, 3'b010, 8'h26, 1'b1, 1'b0, 0);
    @(negedge clk);
    check("bp_out_valid", {31'd0, ov2}, 1);
    check("bp_out_data", {24'd0, od2}, 32'h10);
    repeat (2) @(negedge clk);
    check("bp_hold_data", {24'd0, od2}, 32'h10);
    check("bp_hold_valid", {31'd0, ov2}, 1);
    @(posedge clk);
    #1;
    or2 = 1'b1;
    try_beat(1'b0, 8'h12, 8'h34, 3'b010, 8'h26, 1'b1, 1'b1, 0);
    try_beat(1'b0, 8'h12, 8'h34, 3'b100, 8'hC9, 1'b0, 1'b1, 0);
    drain("bp_drain");

    // Bubble collapse on STAGES=3
    or3 = 1'b0;
    try_beat(1'b1, 8'h5A, 8'hC3, 3'b101, 8'h66, 1'b0, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    try_beat(1'b1, 8'h5A, 8'hC3, 3'b011, 8'hBD, 1'b0, 1'b1, 0);
    try_beat(1'b1, 8'h5A, 8'hC3, 3'b110, 8'h5A, 1'b0, 1'b1, 0);
    try_beat(1'b1, 8'h5A, 8'hC3, 3'b111, 8'hA5, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("bub_out_valid", {31'd0, ov3}, 1);
    check("bub_out_data", {24'd0, od3}, 32'h66);
    @(posedge clk);
    #1;
    or3 = 1'b1;
    drain("bub_drain");

    // Mid-stream asynchronous reset
    or2 = 1'b0;
    try_beat(1'b0, 8'hFF, 8'h01, 3'b000, 8'h01, 1'b1, 1'b1, 0);
    try_beat(1'b0, 8'hFF, 8'h01, 3'b110, 8'hFF, 1'b0, 1'b1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, ov2}, 0);
    check("async_rst_data", {24'd0, od2}, 0);
    q2.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    or2 = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_no_stale", {31'd0, ov2}, 0);
    @(posedge clk);
    #1;

    // Parity vector
    try_beat(1'b0, 8'h07, 8'h00, 3'b001, 8'h07, 1'b1, 1'b1, 2);
    drain("par_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
